// File: rtl/sdspi_arb_pkg.sv
// sdspi_arb_pkg: shared types and sizing helpers for the sdspi host arbiter
package sdspi_arb_pkg;
  typedef enum logic [2:0] {INIT_RST, INIT_WAIT, IDLE, OWN, DRAIN, ERROR} state_t;
  localparam int RST_CYCLES_DEF = 16;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sdspi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req bit at or after ptr wins
module rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] index
);
  logic [W-1:0] j;
  // scan from the farthest offset down so the nearest requester overwrites the result last
  always_comb begin
    valid = 1'b0;
    index = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        valid = 1'b1;
        index = j;
      end
    end
  end
endmodule

// File: rtl/sdspi_arbiter.sv
// sdspi_arbiter: shares one sdspi host between N_REQ requesters with init sequencing and error fencing
module sdspi_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  input  logic [N_REQ-1:0]    req_r_block,
  input  logic [N_REQ-1:0]    req_r_multi_block,
  input  logic [N_REQ-1:0]    req_r_byte,
  input  logic [N_REQ-1:0]    req_w_block,
  input  logic [N_REQ-1:0]    req_w_byte,
  input  logic [32*N_REQ-1:0] req_block_addr,
  input  logic [8*N_REQ-1:0]  req_data_in,
  output logic [N_REQ-1:0]    req_busy,
  output logic [7:0]          data_out,
  output logic                err,
  output logic                spi_rst,
  input  logic                spi_busy,
  input  logic                spi_err,
  input  logic [7:0]          spi_data_out,
  output logic                spi_r_block,
  output logic                spi_r_multi_block,
  output logic                spi_r_byte,
  output logic                spi_w_block,
  output logic                spi_w_byte,
  output logic [31:0]         spi_block_addr,
  output logic [7:0]          spi_data_in
);
  localparam int CW = cnt_w(RST_CYCLES);
  localparam int PW = $clog2(N_REQ);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr, owner, pick, nxt;
  logic          pick_v, own;
  rr_pick #(.N(N_REQ), .W(PW)) u_pick (.req(req), .ptr(ptr), .valid(pick_v), .index(pick));
  assign nxt = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
  assign own = state == OWN;
  assign data_out = spi_data_out;
  assign spi_r_block = own & req_r_block[owner];
  assign spi_r_multi_block = own & req_r_multi_block[owner];
  assign spi_r_byte = own & req_r_byte[owner];
  assign spi_w_block = own & req_w_block[owner];
  assign spi_w_byte = own & req_w_byte[owner];
  assign spi_block_addr = own ? req_block_addr[32*owner +: 32] : '0;
  assign spi_data_in = own ? req_data_in[8*owner +: 8] : '0;
  // only the current owner sees the real host busy; everyone else is told to wait
  always_comb begin
    req_busy = '1;
    if (own) req_busy[owner] = spi_busy;
  end
  // host init, round-robin ownership, drain and error fencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_RST;
      cnt <= '0;
      gnt <= '0;
      err <= 1'b0;
      spi_rst <= 1'b1;
      ptr <= '0;
      owner <= '0;
    end else begin
      case (state)
        INIT_RST:
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state <= INIT_WAIT;
            spi_rst <= 1'b0;
          end else cnt <= cnt + 1'b1;
        INIT_WAIT:
          if (spi_err) begin
            state <= ERROR;
            err <= 1'b1;
          end else if (!spi_busy) state <= IDLE;
        IDLE:
          if (pick_v) begin
            state <= OWN;
            owner <= pick;
            gnt <= N_REQ'(1) << pick;
          end
        OWN:
          if (spi_err) begin
            state <= ERROR;
            err <= 1'b1;
            gnt <= '0;
          end else if (!req[owner]) begin
            gnt <= '0;
            state <= spi_busy ? DRAIN : IDLE;
            if (!spi_busy) ptr <= nxt;
          end
        DRAIN:
          if (spi_err) begin
            state <= ERROR;
            err <= 1'b1;
          end else if (!spi_busy) begin
            state <= IDLE;
            ptr <= nxt;
          end
        ERROR:
          if (req == '0) begin
            state <= INIT_RST;
            cnt <= '0;
            spi_rst <= 1'b1;
          end
        default: state <= INIT_RST;
      endcase
    end
  end
endmodule

// File: tb/tb_sdspi_arbiter.sv
// tb_sdspi_arbiter: randomized and directed checks of sdspi_arbiter against a behavioural model
module tb_sdspi_arbiter;
  localparam int N = 2;
  localparam int RC = 16;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, gnt, r_block, r_multi, r_byte, w_block, w_byte, req_busy;
  logic [32*N-1:0] addr;
  logic [8*N-1:0] din;
  logic [7:0] data_out, spi_dout, s_din;
  logic err, spi_rst, spi_busy, spi_err, s_rb, s_rm, s_rby, s_wb, s_wby;
  logic [31:0] s_addr;
  int m_init, m_owner, m_ptr;
  bit m_wait, m_drain, m_fence, m_err, live;
  int n_tests, n_fail, rst_hi, gnt_hi;

  always #5 clk = ~clk;

  sdspi_arbiter #(.N_REQ(N), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .req_r_block(r_block), .req_r_multi_block(r_multi), .req_r_byte(r_byte),
    .req_w_block(w_block), .req_w_byte(w_byte),
    .req_block_addr(addr), .req_data_in(din), .req_busy(req_busy),
    .data_out(data_out), .err(err), .spi_rst(spi_rst),
    .spi_busy(spi_busy), .spi_err(spi_err), .spi_data_out(spi_dout),
    .spi_r_block(s_rb), .spi_r_multi_block(s_rm), .spi_r_byte(s_rby),
    .spi_w_block(s_wb), .spi_w_byte(s_wby),
    .spi_block_addr(s_addr), .spi_data_in(s_din)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit act;
    logic [N-1:0] eg, eb;
    logic [4:0] es;
    logic [31:0] ea;
    logic [7:0] ed;
    act = m_owner >= 0 && !m_drain;
    eg = '0;
    eb = '1;
    es = '0;
    ea = '0;
    ed = '0;
    if (act) begin
      eg[m_owner] = 1'b1;
      eb[m_owner] = spi_busy;
      es = {r_block[m_owner], r_multi[m_owner], r_byte[m_owner], w_block[m_owner], w_byte[m_owner]};
      ea = addr[32*m_owner +: 32];
      ed = din[8*m_owner +: 8];
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("req_busy", 64'(req_busy), 64'(eb));
    chk("strobes", 64'({s_rb, s_rm, s_rby, s_wb, s_wby}), 64'(es));
    chk("addr", 64'(s_addr), 64'(ea));
    chk("data_in", 64'(s_din), 64'(ed));
    chk("spi_rst", 64'(spi_rst), 64'(m_init > 0));
    chk("err", 64'(err), 64'(m_err));
    chk("data_out", 64'(data_out), 64'(spi_dout));
  endtask

  task automatic fence();
    m_owner = -1;
    m_drain = 1'b0;
    m_wait = 1'b0;
    m_fence = 1'b1;
    m_err = 1'b1;
  endtask

  task automatic release_owner();
    m_ptr = (m_owner + 1) % N;
    m_owner = -1;
    m_drain = 1'b0;
  endtask

  task automatic update_model();
    if (rst) begin
      m_init = RC;
      m_wait = 1'b0;
      m_owner = -1;
      m_drain = 1'b0;
      m_fence = 1'b0;
      m_err = 1'b0;
      m_ptr = 0;
    end else if (m_init > 0) begin
      m_init--;
      if (m_init == 0) m_wait = 1'b1;
    end else if (m_wait) begin
      if (spi_err) fence();
      else if (!spi_busy) m_wait = 1'b0;
    end else if (m_fence) begin
      if (req == '0) begin
        m_fence = 1'b0;
        m_init = RC;
      end
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++)
        if (req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          break;
        end
    end else if (spi_err) fence();
    else if (!m_drain && !req[m_owner]) begin
      if (spi_busy) m_drain = 1'b1;
      else release_owner();
    end else if (m_drain && !spi_busy) release_owner();
  endtask

  task automatic tick();
    #1;
    if (live) check_all();
    if (spi_rst) rst_hi++;
    if (gnt != '0) gnt_hi++;
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    live = 1'b0;
    {req, r_block, r_multi, r_byte, w_block, w_byte} = '0;
    addr = '0;
    din = '0;
    spi_dout = 8'h00;
    spi_err = 1'b0;
    spi_busy = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    tick();
    live = 1'b1;
    rst = 1'b0;
    req = 2'b11;
    rst_hi = 0;
    gnt_hi = 0;
    repeat (40) tick();
    chk("t1_rst_len", 64'(rst_hi), 64'(RC));
    chk("t1_no_gnt_while_busy", 64'(gnt_hi), 64'(0));
    spi_busy = 1'b0;
    tick();
    tick();
    #1 chk("t2_tie_req0", 64'(gnt), 64'(2'b01));
    req = 2'b10;
    tick();
    tick();
    #1 chk("t2_alternate", 64'(gnt), 64'(2'b10));
    req = 2'b00;
    tick();
    req = 2'b11;
    tick();
    tick();
    #1 chk("t2_back_to_0", 64'(gnt), 64'(2'b01));
    req = 2'b10;
    tick();
    tick();
    w_block = 2'b10;
    r_block = 2'b01;
    addr = {32'h0000_1234, 32'hDEAD_BEEF};
    din = {8'hA5, 8'h3C};
    #1 chk("t3_addr", 64'(s_addr), 64'h1234);
    chk("t3_data", 64'(s_din), 64'hA5);
    chk("t3_w_block", 64'(s_wb), 64'(1));
    chk("t3_r_block_dropped", 64'(s_rb), 64'(0));
    tick();
    {w_block, r_block} = '0;
    req = 2'b00;
    spi_busy = 1'b1;
    tick();
    #1 chk("t4_drain_gnt0", 64'(gnt), 64'(0));
    req = 2'b01;
    gnt_hi = 0;
    repeat (10) tick();
    chk("t4_no_gnt_in_drain", 64'(gnt_hi), 64'(0));
    spi_busy = 1'b0;
    tick();
    #1 chk("t4_idle_gap", 64'(gnt), 64'(0));
    tick();
    #1 chk("t4_next_gnt", 64'(gnt), 64'(2'b01));
    spi_err = 1'b1;
    tick();
    spi_err = 1'b0;
    r_block = 2'b01;
    #1 chk("t5_err", 64'(err), 64'(1));
    chk("t5_gnt0", 64'(gnt), 64'(0));
    chk("t5_strobe0", 64'(s_rb), 64'(0));
    repeat (3) tick();
    r_block = 2'b00;
    req = 2'b00;
    rst_hi = 0;
    repeat (20) tick();
    chk("t5_reinit_len", 64'(rst_hi), 64'(RC));
    req = 2'b01;
    tick();
    tick();
    #1 chk("t5_resume_gnt", 64'(gnt), 64'(2'b01));
    chk("t5_err_sticky", 64'(err), 64'(1));
    req = 2'b00;
    tick();
    req = 2'b10;
    tick();
    tick();
    spi_busy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("t6_spi_rst", 64'(spi_rst), 64'(1));
    chk("t6_gnt0", 64'(gnt), 64'(0));
    chk("t6_err0", 64'(err), 64'(0));
    req = 2'b11;
    spi_busy = 1'b0;
    repeat (RC + 2) tick();
    #1 chk("t6_ptr_reset", 64'(gnt), 64'(2'b01));
    repeat (3000) begin
      rst = ($urandom % 400) == 0;
      req = N'($urandom);
      r_block = N'($urandom);
      r_multi = N'($urandom);
      r_byte = N'($urandom);
      w_block = N'($urandom);
      w_byte = N'($urandom);
      addr = {$urandom, $urandom};
      din = 16'($urandom);
      spi_dout = 8'($urandom);
      spi_busy = 1'($urandom);
      spi_err = ($urandom % 100) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdspi_arbiter.md
Name: sdspi_arbiter

Overview:
Shares one sdspihost instance between N_REQ requesters, e.g. a test-vector loader and a results writer in the autotest flow.
- Sequences host initialisation after reset.
- Grants the host round-robin, holding each grant for a full transaction.
- Muxes the owner's strobes, address and write data onto the host.
- Fences requesters off after a host error.

Parameters:
N_REQ, 2, number of requesters (2..4)
RST_CYCLES, 16, cycles spi_rst is held high during init (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  N_REQ  per-requester request, held for the whole transaction
gnt  out  N_REQ  one-hot grant
req_r_block  in  N_REQ  per-requester read-block strobe
req_r_multi_block  in  N_REQ  per-requester multi-block read strobe
req_r_byte  in  N_REQ  per-requester read-byte strobe
req_w_block  in  N_REQ  per-requester write-block strobe
req_w_byte  in  N_REQ  per-requester write-byte strobe
req_block_addr  in  32*N_REQ  per-requester block address, slice i = [32*i+:32]
req_data_in  in  8*N_REQ  per-requester write byte, slice i = [8*i+:8]
req_busy  out  N_REQ  per-requester busy view
data_out  out  8  host read byte, broadcast to all requesters
err  out  1  sticky host-error flag
spi_rst  out  1  host reset
spi_busy  in  1  host busy
spi_err  in  1  host error
spi_r_block, spi_r_multi_block, spi_r_byte, spi_w_block, spi_w_byte  out  1 each  host strobes
spi_block_addr  out  32  host block address
spi_data_in  out  8  host write byte

Behaviour:
- Reset (rst high at a clock edge):
  - state <= INIT_RST; counter cleared; gnt=0; err=0; spi_rst=1.
  - All host strobes 0; spi_block_addr=0; spi_data_in=0; req_busy all 1.
  - Round-robin pointer <= 0.
- INIT_RST:
  - spi_rst=1 for exactly RST_CYCLES cycles, then -> INIT_WAIT.
- INIT_WAIT:
  - spi_rst=0.
  - spi_busy low for one sampled cycle -> IDLE.
  - spi_err high -> ERROR.
- IDLE:
  - Scan req starting at the pointer and wrap modulo N_REQ; first set bit wins.
  - Registered gnt: asserted the cycle after req is seen, i.e. 1-cycle latency. -> OWN.
- OWN:
  - Host strobes, spi_block_addr and spi_data_in are a combinational mux of the owner's slice; all other inputs are ignored.
  - req_busy[owner]=spi_busy; every other requester's req_busy is 1.
  - Owner deasserts req with spi_busy low: gnt cleared next cycle, pointer <= owner+1 (wrap), -> IDLE.
  - Owner deasserts req with spi_busy high: -> DRAIN.
- DRAIN:
  - gnt cleared and strobes forced 0; wait for spi_busy low, then pointer update and -> IDLE.
  - Guarantees at least one idle cycle between owners.
- Not granted: strobes from a requester are dropped silently, never queued.
- data_out = spi_data_out passthrough in every state; consumers qualify it with their own gnt/req_busy.
- Host error:
  - spi_err high in OWN or DRAIN -> ERROR.
  - ERROR: gnt=0, strobes 0, err=1 (sticky), req_busy all 1.
  - When req == 0 -> INIT_RST for a full re-init; err stays 1 until rst.
- Simultaneous requests: the pointer resolves them. Pointer starts at 0 after reset, so requester 0 wins the first tie.
- rst mid-transaction: aborts immediately; the host is re-reset through INIT_RST.
- Owner reasserts req in the same cycle gnt drops: treated as a new request, but the pointer has already advanced past it.

Decomposition:
- Package sdspi_arb_pkg: state enum (INIT_RST, INIT_WAIT, IDLE, OWN, DRAIN, ERROR) and a localparam for counter width, $clog2(RST_CYCLES+1).
- One sub-module: rr_pick. Combinational round-robin selector with inputs req and pointer, outputs valid and index. It is reusable by other shared-resource arbiters.

Test Plan:
1. Reset, spi_busy=1 for 40 cycles then 0 -> spi_rst high exactly 16 cycles; first gnt only after spi_busy falls; gnt=0 throughout.
2. req=2'b11 in the same cycle from IDLE with pointer 0 -> gnt=2'b01 one cycle later. Release while idle -> gnt=2'b10 on the next arbitration. Re-request both -> 2'b01 again, confirming alternation.
3. Owner 1 issues w_block with addr 0x0000_1234 and data 0xA5 -> spi_block_addr=0x0000_1234, spi_data_in=0xA5 the same cycle. Requester 0 strobes r_block during this and never reaches the host.
4. Owner drops req while spi_busy=1 for 10 more cycles -> DRAIN; gnt=0 immediately; next gnt issued no earlier than the cycle after spi_busy falls.
5. spi_err pulse during OWN -> err=1, gnt=0, strobes 0. After all req are low: spi_rst high 16 cycles, then IDLE grants resume with err still 1.
6. rst asserted mid-transfer while spi_busy=1 -> next cycle spi_rst=1, gnt=0, pointer 0, err=0.
